// File: rtl/pgm_prefetch.sv
// Instruction prefetch queue between the combinational program ROM and the decode stage.
// Optional macro PGM_PREFETCH_HOLD_EN adds fetch_hold, which pauses ROM fetches with the queue intact.
module pgm_prefetch #(
    parameter int                            bus_addr_pgm_width = 11,
    parameter int                            DEPTH              = 4,
    parameter logic [bus_addr_pgm_width-1:0] reset_vector       = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [bus_addr_pgm_width-1:0] pmem_a,
    input  logic [15:0]                   pmem_d,
    input  logic                          flush,
    input  logic [bus_addr_pgm_width-1:0] flush_addr,
`ifdef PGM_PREFETCH_HOLD_EN
    input  logic                          fetch_hold,
`endif
    output logic [15:0]                   instr,
    output logic [bus_addr_pgm_width-1:0] instr_addr,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int AW = bus_addr_pgm_width;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] fp_q, fp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] count_q, count_d;
    logic          hold;
    logic          pop;
    logic          push;

`ifdef PGM_PREFETCH_HOLD_EN
    assign hold = fetch_hold;
`else
    assign hold = 1'b0;
`endif

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready & ~flush;
    // A full queue still accepts a new word when the head leaves in the same cycle.
    assign push        = ~flush & ~hold & ((count_q < CW'(DEPTH)) | pop);

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        fp_d    = fp_q;
        rp_d    = rp_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (flush) begin
            fp_d    = flush_addr;
            rp_d    = '0;
            wp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fp_d = fp_q + AW'(1);
                wp_d = wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fp_q    <= reset_vector;
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
            // NOTE: the storage is cleared only so instr/instr_addr read as 0 after reset;
            // correctness never depends on it, since empty entries are never presented.
            mem_q   <= '{default: '0};
        end else begin
            fp_q    <= fp_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wp_q] <= '{addr: fp_q, data: pmem_d};
            end
        end
    end

    assign pmem_a     = fp_q;
    assign instr      = mem_q[rp_q].data;
    assign instr_addr = mem_q[rp_q].addr;
    assign level      = count_q;

endmodule

// File: doc/pgm_prefetch.md
Name: pgm_prefetch

Overview:
- Instruction prefetch queue between the program ROM and the XMEGA CPU decode stage.
- Drives the ROM word address and captures the 16-bit ROM word in the same cycle, since the ROM read is combinational.
- Buffers up to DEPTH words, each tagged with its word address.
- Presents the words in order to the core with a valid/ready handshake, and supports flush-and-redirect for jumps, branches, calls and interrupts.

Parameters:
- bus_addr_pgm_width, 11, ROM word-address width; matches the ROM's parameter of the same name.
- DEPTH, 4, queue entries; must be a power of two and at least 2.
- reset_vector, 0, word address fetched first after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on clk rising edge).
- pmem_a  out  bus_addr_pgm_width  ROM word address; equals the fetch pointer fp (combinational from the register).
- pmem_d  in  16  ROM data for pmem_a, valid in the same cycle.
- flush  in  1  discard the queue and redirect fetch.
- flush_addr  in  bus_addr_pgm_width  new fetch address, used when flush=1.
- instr  out  16  head-of-queue instruction word.
- instr_addr  out  bus_addr_pgm_width  word address of instr.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  core accepts the head this cycle.
- level  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=0 at an edge):
  - fp=reset_vector; count=0; read and write pointers=0.
  - instr_valid=0, level=0, pmem_a=reset_vector.
  - instr and instr_addr are don't-care while instr_valid=0; the implementation drives 0 after reset.
  - Reset takes priority over flush, push and pop.
- pop = instr_valid & instr_ready & ~flush.
- push = ~flush & (count<DEPTH | pop).
  - Push is allowed when full only if a pop happens in the same cycle.
- On push:
  - Entry[wp] <= {fp, pmem_d}; wp++ (mod DEPTH).
  - fp <= fp+1, wrapping from 2^bus_addr_pgm_width-1 to 0 with no error.
- On pop: rp++ (mod DEPTH).
- count update: count <= count + push - pop. Push and pop together leave count unchanged; this holds at full and at count=1.
- Outputs from queue state:
  - instr_valid = (count!=0).
  - instr and instr_addr = entry[rp], read from registered storage with no combinational path from pmem_d.
  - level = count.
- Flush (priority over push and pop):
  - count<=0; rp<=0; wp<=0; fp<=flush_addr.
  - instr_ready is ignored in the flush cycle; the head is discarded, not consumed.
- Flush latency:
  - Flush asserted in cycle N → pmem_a=flush_addr in N+1, with push that cycle.
  - Cycle N+2: instr_valid=1, instr_addr=flush_addr.
- Back-to-back flushes: each flush overrides the previous one; only the last flush_addr takes effect.
- Steady state: with instr_ready held at 1 the queue sustains one instruction per cycle after a single-cycle fill latency.
- Stall: with instr_ready=0 the queue fills to DEPTH, then fp freezes.
  - pmem_a stays stable at the next address to fetch.
  - Head outputs stay stable until accepted.
- No backward path: the block never asserts anything toward the ROM except pmem_a.

Optional Feature:
- Macro: PGM_PREFETCH_HOLD_EN.
- When defined:
  - Adds input port fetch_hold (1 bit).
  - While fetch_hold=1, push is forced to 0 and fp is held; pops continue normally.
  - Lets the core borrow the ROM port (e.g. for LPM/ELPM) with the queue intact.
  - Flush still takes effect during hold: fp<=flush_addr, queue empties, no push until hold drops.
- When not defined: the port does not exist, and push follows only the rules above.

Test Plan:
- Reset release, ROM mem[i]=16'hA000+i, instr_ready=1 → from cycle 2 after reset, instr=A000, A001, A002… and instr_addr=0, 1, 2… each cycle; level never exceeds 1.
- instr_ready=0 for 10 cycles after reset → level rises to 4 and holds; pmem_a=4 and stable; instr=A000. Then ready=1 → A000…A003 followed by A004 with no gap or duplicate.
- Flush with flush_addr=0x123 while level=3 and ready=1 → no pop that cycle; next cycle instr_valid=0 and pmem_a=0x123; cycle after, instr_addr=0x123, instr=A123.
- Flush to 0x7FE (width 11), ready=1 → instr_addr sequence 7FE, 7FF, 000, 001.
- rst=0 asserted mid-stream with the queue full and flush=1 → next cycle instr_valid=0, level=0, pmem_a=reset_vector.
- With PGM_PREFETCH_HOLD_EN: fill 2 entries, fetch_hold=1, ready=1 → both entries drain, then instr_valid=0 and pmem_a is frozen; release hold → fetching resumes at the frozen address.
